path_streamer: RTL

PATH_STREAMER -- requirements
Module: path_streamer

---
 rtl/path_streamer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/path_streamer.sv
// rtl/path_streamer.sv - buffers a path of node indices and streams them to the path mapper.
// Optional write range check on wr_node is enabled by defining PATH_RANGE_CHECK_EN.
module path_streamer #(
  parameter int DEPTH    = 16,
  parameter int NODE_MAX = 29
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_node,
  input  logic       wr_last,
  input  logic       send,
  output logic       path_input,
  output logic [4:0] path_planned,
  output logic       busy,
  output logic       done,
  output logic [4:0] node_count,
  output logic       full,
  output logic       err
);

  localparam int         PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_V  = 5'(DEPTH);
  localparam logic [4:0] NODE_LIM = 5'(NODE_MAX);
`ifdef PATH_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, READY, SEND, GAP} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]         count_q, count_d;
  logic [4:0]         rem_q, rem_d;
  logic               path_input_q, path_input_d;
  logic [4:0]         path_planned_q, path_planned_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               full_q, full_d;
  logic               err_q, err_d;
  logic               buf_we;
  logic [4:0]         buf_q [DEPTH];
  logic               send_ok;
  logic               wr_bad;

  assign send_ok = send && (count_q != 5'd0);
  assign wr_bad  = RANGE_CHECK && (wr_node > NODE_LIM);

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    rem_d          = rem_q;
    err_d          = err_q;
    path_input_d   = 1'b0;
    path_planned_d = 5'd0;
    done_d         = 1'b0;
    buf_we         = 1'b0;
    case (state_q)
      IDLE, READY: begin
        // An accepted send wins over a write presented in the same cycle.
        if (send_ok) begin
          state_d  = SEND;
          rd_ptr_d = '0;
          rem_d    = count_q;
          err_d    = 1'b0;
        end else if (state_q == IDLE && wr_en && !full_q) begin
          if (wr_bad) begin
            err_d = 1'b1;
          end else begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 5'd1;
            if (wr_last) state_d = READY;
          end
        end
      end
      SEND: begin
        if (rem_q != 5'd0) begin
          path_input_d   = 1'b1;
          path_planned_d = buf_q[rd_ptr_q];
          rd_ptr_d       = rd_ptr_q + 1'b1;
          rem_d          = rem_q - 5'd1;
        end else begin
          done_d   = 1'b1;
          count_d  = 5'd0;
          wr_ptr_d = '0;
          state_d  = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SEND) || (state_d == GAP);
    full_d = (count_d == DEPTH_V);
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= 5'd0;
      rem_q          <= 5'd0;
      path_input_q   <= 1'b0;
      path_planned_q <= 5'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      full_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rem_q          <= rem_d;
      path_input_q   <= path_input_d;
      path_planned_q <= path_planned_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      full_q         <= full_d;
      err_q          <= err_d;
    end
  end

  // Node storage is left unreset; only the pointers define valid contents.
  always_ff @(posedge clk_50M) begin
    if (buf_we) buf_q[wr_ptr_q] <= wr_node;
  end

  assign path_input   = path_input_q;
  assign path_planned = path_planned_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign node_count   = count_q;
  assign full         = full_q;
  assign err          = err_q;

endmodule
